// File: rtl/delta_sigma_out_if.sv
// Sample write port from the synth core into the delta-sigma output stage.
// Fire-and-forget: no ready, one write per cycle.
interface delta_sigma_out_if #(
  parameter int SAMPLE_W = 10
);
  logic                       smp_valid;
  logic [2:0]                 smp_chan;
  logic signed [SAMPLE_W-1:0] smp_value;

  modport master (output smp_valid, output smp_chan, output smp_value);
  modport slave  (input  smp_valid, input  smp_chan, input  smp_value);
endinterface

// File: rtl/delta_sigma_out.sv
// Eight-channel first-order delta-sigma output stage with frame-synchronous commit.
// Optional LFSR carry-in dither is enabled by defining DELTA_SIGMA_DITHER_EN.
module delta_sigma_lane #(
  parameter int SAMPLE_W = 10
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic signed [SAMPLE_W-1:0] wr_value,
  input  logic                       commit,
  input  logic                       cin,
  output logic                       bit_out
);
  logic signed [SAMPLE_W-1:0] shadow;
  logic signed [SAMPLE_W-1:0] active;
  logic        [SAMPLE_W-1:0] acc;
  logic        [SAMPLE_W-1:0] u;
  logic        [SAMPLE_W:0]   sum;

  // Flipping the MSB turns signed midscale into the unsigned half-scale code.
  assign u   = {~active[SAMPLE_W-1], active[SAMPLE_W-2:0]};
  assign sum = {1'b0, acc} + {1'b0, u} + {{SAMPLE_W{1'b0}}, cin};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow  <= '0;
      active  <= '0;
      acc     <= '0;
      bit_out <= 1'b0;
    end else begin
      if (wr_en)  shadow <= wr_value;
      // Same-cycle write: commit takes the old shadow, which is the pre-edge value.
      if (commit) active <= shadow;
      acc     <= sum[SAMPLE_W-1:0];
      bit_out <= sum[SAMPLE_W];
    end
  end
endmodule

module delta_sigma_out #(
  parameter int SAMPLE_W = 10,
  parameter int NUM_CH   = 8
) (
  input  logic              IO_main_clk,
  input  logic              IO_rst,
  input  logic              IO_audio_clk,
  delta_sigma_out_if.slave  smp,
  output logic [NUM_CH-1:0] IO_chan,
  output logic [NUM_CH-1:0] IO_stale
);
  logic [NUM_CH-1:0] written;
  logic [NUM_CH-1:0] written_nxt;
  logic [NUM_CH-1:0] cin;

`ifdef DELTA_SIGMA_DITHER_EN
  logic [15:0] lfsr;

  // Right-shifting Galois form of x^16+x^14+x^13+x^11+1.
  always_ff @(posedge IO_main_clk or posedge IO_rst) begin
    if (IO_rst) lfsr <= 16'hACE1;
    else        lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  end

  assign cin = lfsr[NUM_CH-1:0];
`else
  assign cin = '0;
`endif

  // A write on the commit edge belongs to the new frame, so it survives the clear.
  always_comb begin
    written_nxt = IO_audio_clk ? '0 : written;
    if (smp.smp_valid) written_nxt[smp.smp_chan] = 1'b1;
  end

  always_ff @(posedge IO_main_clk or posedge IO_rst) begin
    if (IO_rst) begin
      written  <= '0;
      IO_stale <= '0;
    end else begin
      written <= written_nxt;
      if (IO_audio_clk) IO_stale <= ~written;
    end
  end

  for (genvar n = 0; n < NUM_CH; n++) begin : g_lane
    delta_sigma_lane #(.SAMPLE_W(SAMPLE_W)) u_lane (
      .clk      (IO_main_clk),
      .rst      (IO_rst),
      .wr_en    (smp.smp_valid && (smp.smp_chan == 3'(n))),
      .wr_value (smp.smp_value),
      .commit   (IO_audio_clk),
      .cin      (cin[n]),
      .bit_out  (IO_chan[n])
    );
  end
endmodule

// File: tb/tb_delta_sigma_out.sv
// Scoreboard bench for delta_sigma_out: expected ones-densities are queued at
// commit time from a behavioural shadow/active/written model and checked per window.
module tb_delta_sigma_out;
  localparam int W = 10;
  localparam int N = 8;
  localparam int WIN = 1 << W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic audio = 1'b0;
  logic [N-1:0] chan_o;
  logic [N-1:0] stale_o;

  delta_sigma_out_if #(.SAMPLE_W(W)) ifc ();

  delta_sigma_out #(.SAMPLE_W(W), .NUM_CH(N)) dut (
    .IO_main_clk  (clk),
    .IO_rst       (rst),
    .IO_audio_clk (audio),
    .smp          (ifc.slave),
    .IO_chan      (chan_o),
    .IO_stale     (stale_o)
  );

  always #5 clk = ~clk;

  typedef struct { int ch; int ones; } exp_t;
  exp_t sb[$];

  int total = 0;
  int bad = 0;

  int m_shadow [N];
  int m_active [N];
  logic [N-1:0] m_written;
  logic [N-1:0] m_stale;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_shadow[i] = 0;
      m_active[i] = 0;
    end
    m_written = '0;
    m_stale = '0;
  endtask

  task automatic model_commit();
    m_stale = ~m_written;
    for (int i = 0; i < N; i++) m_active[i] = m_shadow[i];
    m_written = '0;
  endtask

  // One write cycle, optionally coinciding with the audio strobe.
  task automatic write_ch(input int ch, input int val, input bit with_commit);
    ifc.smp_valid = 1'b1;
    ifc.smp_chan  = 3'(ch);
    ifc.smp_value = W'(val);
    audio = with_commit;
    if (with_commit) model_commit();
    m_shadow[ch] = val;
    m_written[ch] = 1'b1;
    tick();
    ifc.smp_valid = 1'b0;
    audio = 1'b0;
  endtask

  task automatic commit();
    audio = 1'b1;
    model_commit();
    tick();
    audio = 1'b0;
  endtask

  task automatic check_stale(input string name);
    total++;
    if (stale_o !== m_stale) begin
      bad++;
      $display("FAIL %s: stale got %h expected %h", name, stale_o, m_stale);
    end
  endtask

  // Push expected densities, count ones over one full accumulator period, pop and compare.
  task automatic measure(input string name);
    int cnt [N];
    exp_t e;
    for (int i = 0; i < N; i++) begin
      cnt[i] = 0;
      sb.push_back('{ch: i, ones: m_active[i] + (WIN / 2)});
    end
    for (int k = 0; k < WIN; k++) begin
      tick();
      for (int i = 0; i < N; i++) cnt[i] += int'(chan_o[i]);
    end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      total++;
`ifdef DELTA_SIGMA_DITHER_EN
      if (cnt[e.ch] < e.ones || cnt[e.ch] > e.ones + 2) begin
`else
      if (cnt[e.ch] !== e.ones) begin
`endif
        bad++;
        $display("FAIL %s ch%0d density: got %0d expected %0d", name, e.ch, cnt[e.ch], e.ones);
      end
    end
  endtask

  task automatic test_reset();
    model_reset();
    ifc.smp_valid = 1'b0;
    ifc.smp_chan  = '0;
    ifc.smp_value = '0;
    rst = 1'b1;
    repeat (3) tick();
    total++;
    if (chan_o !== 8'h00) begin
      bad++;
      $display("FAIL reset chan: got %h expected 00", chan_o);
    end
    check_stale("reset");
    rst = 1'b0;
    tick();
  endtask

  task automatic test_midscale();
    logic prev;
    logic alt_ok;
    write_ch(0, 0, 1'b0);
    commit();
    total++;
    if (stale_o !== 8'hFE) begin
      bad++;
      $display("FAIL midscale stale: got %h expected fe", stale_o);
    end
    alt_ok = 1'b1;
    tick();
    prev = chan_o[0];
    for (int k = 0; k < 16; k++) begin
      tick();
      if (chan_o[0] === prev) alt_ok = 1'b0;
      prev = chan_o[0];
    end
`ifndef DELTA_SIGMA_DITHER_EN
    total++;
    if (alt_ok !== 1'b1) begin
      bad++;
      $display("FAIL midscale toggle: got %b expected 1", alt_ok);
    end
`endif
    measure("midscale");
  endtask

  task automatic test_extremes();
    write_ch(3, -512, 1'b0);
    write_ch(5, 511, 1'b0);
    commit();
    check_stale("extremes");
    measure("extremes");
  endtask

  task automatic test_same_cycle();
    write_ch(2, 100, 1'b1);
    check_stale("same_cycle_first");
    measure("same_cycle_first");
    commit();
    total++;
    if (stale_o[2] !== 1'b0) begin
      bad++;
      $display("FAIL same_cycle stale2: got %b expected 0", stale_o[2]);
    end
    check_stale("same_cycle_second");
    measure("same_cycle_second");
  endtask

  task automatic test_stale_frames();
    for (int f = 0; f < 2; f++) begin
      repeat (20) tick();
      write_ch(7, 50 * (f + 1), 1'b0);
      repeat (20) tick();
      commit();
      total++;
      if (stale_o !== 8'h7F) begin
        bad++;
        $display("FAIL stale_frame%0d: got %h expected 7f", f, stale_o);
      end
    end
    measure("stale_frames");
  endtask

  task automatic test_reset_midframe();
    write_ch(1, 300, 1'b0);
    commit();
    measure("pre_reset");
    write_ch(4, 200, 1'b0);
    repeat (7) tick();
    #3;
    rst = 1'b1;
    model_reset();
    #1;
    total++;
    if (chan_o !== 8'h00) begin
      bad++;
      $display("FAIL async_reset chan: got %h expected 00", chan_o);
    end
    check_stale("async_reset");
    @(negedge clk);
    rst = 1'b0;
    tick();
    measure("post_reset");
    check_stale("post_reset_hold");
    commit();
    total++;
    if (stale_o !== 8'hFF) begin
      bad++;
      $display("FAIL post_reset strobe stale: got %h expected ff", stale_o);
    end
    measure("post_reset_commit");
  endtask

  task automatic test_dither();
    int ones;
    write_ch(0, -512, 1'b0);
    commit();
    ones = 0;
`ifdef DELTA_SIGMA_DITHER_EN
    for (int k = 0; k < 65536; k++) begin
      tick();
      ones += int'(chan_o[0]);
    end
    total++;
    if (ones == 0 || ones > 200) begin
      bad++;
      $display("FAIL dither ones: got %0d expected nonzero small count", ones);
    end
`else
    for (int k = 0; k < 4 * WIN; k++) begin
      tick();
      ones += int'(chan_o[0]);
    end
    total++;
    if (ones !== 0) begin
      bad++;
      $display("FAIL no_dither ones: got %0d expected 0", ones);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_midscale();
    test_extremes();
    test_same_cycle();
    test_stale_frames();
    test_reset_midframe();
    test_dither();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/delta_sigma_out.md
Name: delta_sigma_out

Overview:
- Final output stage of the FM synth: receives per-channel signed samples from the synth core and drives the eight 1-bit channel pins (A–H) through first-order delta-sigma modulators clocked at the main clock.
- Sample writes land in shadow registers. All eight channels commit together on the audio-rate strobe, so every pin changes sample on the same cycle.
- Per-channel stale flags report channels the core did not refresh in the previous audio frame.

Parameters:
- SAMPLE_W, 10, sample width, signed two's complement; legal range 4–16.
- NUM_CH, 8, number of channels; fixed to 8 for this build, with 3-bit channel index.

Ports:
- IO_main_clk  in  1  main clock (66.5 MHz internal oscillator).
- IO_rst  in  1  asynchronous reset, active-high.
- IO_audio_clk  in  1  audio-rate strobe, one main-clock cycle wide (main/1508).
- IO_smp_valid  in  1  sample write strobe.
- IO_smp_chan  in  3  target channel index for the write.
- IO_smp_value  in  SAMPLE_W  signed sample to write.
- IO_chan  out  8  modulator bitstreams; bit0 = chan A … bit7 = chan H; registered.
- IO_stale  out  8  per-channel flag: channel not written during the last completed frame.

Behaviour:
- Reset (async, IO_rst=1):
  - shadow[n] = 0 and active[n] = 0 (signed midscale).
  - acc[n] = 0, IO_chan = 8'h00, IO_stale = 8'h00, written mask = 0.
  - Outputs hold at these values until the first rising IO_main_clk after IO_rst deasserts.
- Write:
  - When IO_smp_valid=1, on that clock edge shadow[IO_smp_chan] <= IO_smp_value and written[IO_smp_chan] <= 1.
  - Writes are accepted every cycle; there is no backpressure and no ready signal.
- Commit:
  - When IO_audio_clk=1, on that edge active[n] <= shadow[n] for all n.
  - On the same edge, IO_stale <= ~written and written <= 0.
- Simultaneous write and commit (same cycle):
  - active receives the pre-write shadow value; the new value becomes active at the next commit.
  - For written, the write wins: written[IO_smp_chan] <= 1, counted toward the new frame.
- Offset conversion: u[n] = active[n] with MSB inverted (SAMPLE_W bits, unsigned). -2^(W-1) maps to 0; 2^(W-1)-1 maps to 2^W-1.
- Modulator, every cycle per channel:
  - sum = {1'b0, acc[n]} + {1'b0, u[n]}, SAMPLE_W+1 bits.
  - acc[n] <= sum[SAMPLE_W-1:0]; IO_chan[n] <= sum[SAMPLE_W].
  - Ones-density = u/2^W exactly over 2^W cycles.
  - Accumulator wraps mod 2^W; no saturation is needed.
- Latency:
  - Write to active: up to one frame, applied at the next IO_audio_clk.
  - Commit to first affected output bit: 2 cycles (active register, then modulator output register).
- Boundaries:
  - Most-negative sample gives a constant 0 output.
  - Most-positive sample gives one zero per 2^W cycles.
  - Midscale gives an alternating 0/1 pattern after acc settles.
- Reset mid-frame discards shadow contents and pending written bits.
- No state machine beyond the commit strobe; all channels are processed in parallel, not time-multiplexed.

Optional Feature:
- Macro: DELTA_SIGMA_DITHER_EN.
- Defined:
  - A 16-bit Galois LFSR (taps x^16+x^14+x^13+x^11+1, reset seed 16'hACE1) advances every cycle.
  - lfsr[n] is added as carry-in to channel n's sum, which breaks idle tones.
  - Mean density rises by 0.5 LSB; most-negative input is no longer a constant 0.
- Undefined: no LFSR logic exists; behaviour is exactly as described above.

Test Plan:
- Reset, then write ch0 = 0 and strobe IO_audio_clk → from commit+2 cycles, IO_chan[0] toggles 1,0,1,0…; exactly 512 ones per 1024 cycles; IO_stale = 8'hFE after that strobe.
- Write ch3 = -512 and ch5 = +511, then strobe → IO_chan[3] constant 0; IO_chan[5] has 1023 ones per 1024 cycles.
- Write ch2 = 100 on the same cycle as IO_audio_clk → ch2 output density is unchanged that frame and becomes 612/1024 after the next strobe; IO_stale[2] = 0 after the next strobe even with no further write.
- Strobe for two frames, writing only ch7 each frame → IO_stale = 8'h7F after each strobe; written mask clears each frame.
- Assert IO_rst asynchronously mid-frame with ch1 = 300 active → IO_chan = 0 immediately; after release with no writes, all channels give 50% density and IO_stale = 8'h00 until the first strobe.
- With DELTA_SIGMA_DITHER_EN, input -512 → ch0 shows nonzero ones (about 32768/65536 carries); compile without the macro → constant 0.
